// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader.
// Holds the legal digit patterns (bit6=a .. bit0=g, 1=lit), the blank
// pattern and the reader state encoding.
package seg7_pkg;

  localparam logic [6:0] PAT_0 = 7'b1111110;
  localparam logic [6:0] PAT_1 = 7'b0110000;
  localparam logic [6:0] PAT_2 = 7'b1101101;
  localparam logic [6:0] PAT_3 = 7'b1111001;
  localparam logic [6:0] PAT_4 = 7'b0110011;
  localparam logic [6:0] PAT_5 = 7'b1011011;
  localparam logic [6:0] PAT_6 = 7'b1011111;
  localparam logic [6:0] PAT_7 = 7'b1110000;
  localparam logic [6:0] BLANK = 7'b0000000;

  // IDLE: blank accepted, TRACK: candidate not yet stable,
  // LOCKED: legal pattern accepted, FAULT: illegal pattern accepted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational classifier for a seven-segment pattern.
// Ports:
//   pattern : 7-bit segment pattern (bit6=a .. bit0=g)
//   code    : digit value 0..7 when legal, 0 otherwise
//   legal   : pattern is one of the eight digit patterns
//   blank   : pattern has no segment lit
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] code,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    code  = 3'd0;
    legal = 1'b1;
    blank = 1'b0;
    case (pattern)
      PAT_0:   code = 3'd0;
      PAT_1:   code = 3'd1;
      PAT_2:   code = 3'd2;
      PAT_3:   code = 3'd3;
      PAT_4:   code = 3'd4;
      PAT_5:   code = 3'd5;
      PAT_6:   code = 3'd6;
      PAT_7:   code = 3'd7;
      BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment display reader: debounces strobed segment samples and
// reports the accepted digit.
// A pattern is accepted once STABLE_CNT consecutive strobed samples agree.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   seg_in     : segment lines, bit6=a .. bit0=g, 1=lit
//   seg_strobe : qualifies seg_in; samples ignored while low
//   code       : last accepted legal digit
//   code_valid : one-cycle pulse when a new legal digit is accepted
//   code_err   : one-cycle pulse when a new illegal pattern is accepted
//   stable     : high while the accepted pattern is legal and unchanged
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_strobe,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       code_err,
  output logic       stable
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  state_t     state, state_next;
  logic [6:0] cand, cand_next;
  logic [3:0] cnt, cnt_next;
  logic [6:0] prev, prev_next;
  logic [2:0] code_next;
  logic       valid_next, err_next, stable_next;
  logic       differ, accept;

  logic [2:0] dec_code;
  logic       dec_legal, dec_blank;

  // The accepted pattern is always the current sample, so classify seg_in.
  seg7_pattern_decode u_decode (
    .pattern (seg_in),
    .code    (dec_code),
    .legal   (dec_legal),
    .blank   (dec_blank)
  );

  always_comb begin
    state_next  = state;
    cand_next   = cand;
    cnt_next    = cnt;
    prev_next   = prev;
    code_next   = code;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    stable_next = stable;
    differ      = (seg_in != cand);
    accept      = 1'b0;
    if (seg_strobe) begin
      if (differ) begin
        cand_next   = seg_in;
        cnt_next    = 4'd1;
        state_next  = TRACK;
        stable_next = 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt_next = cnt + 4'd1;
      end
      // A new candidate counts as tracking, so STABLE_CNT=1 accepts at once.
      accept = (differ || state == TRACK) && (cnt_next == CNT_MAX);
      if (accept) begin
        prev_next = seg_in;
        if (dec_blank) begin
          state_next  = IDLE;
          stable_next = 1'b0;
        end else if (dec_legal) begin
          state_next  = LOCKED;
          stable_next = 1'b1;
          if (seg_in != prev) begin
            valid_next = 1'b1;
            code_next  = dec_code;
          end
        end else begin
          state_next  = FAULT;
          stable_next = 1'b0;
          err_next    = (seg_in != prev);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= BLANK;
      cnt        <= 4'd0;
      prev       <= BLANK;
      code       <= 3'd0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
      stable     <= 1'b0;
    end else begin
      state      <= state_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      prev       <= prev_next;
      code       <= code_next;
      code_valid <= valid_next;
      code_err   <= err_next;
      stable     <= stable_next;
    end
  end

endmodule
